// File: rtl/fpu_rnd_pkg.sv
// Shared types and constants for the rounder representation pipeline.
// Format codes, precisions and the kept-width helper.
package fpu_rnd_pkg;

  typedef enum logic [1:0] {
    FMT_SINGLE  = 2'b00,
    FMT_DOUBLE  = 2'b01,
    FMT_HALF    = 2'b10,
    FMT_ILLEGAL = 2'b11
  } fmt_e;

  localparam int P_HALF   = 11;
  localparam int P_SINGLE = 24;
  localparam int P_DOUBLE = 53;

  localparam int STICKY_CHUNK = 8;

  // Kept width: significand plus round bit.
  function automatic int keep_w(fmt_e f);
    int k;
    k = 0;
    case (f)
      FMT_HALF:   k = P_HALF + 1;
      FMT_SINGLE: k = P_SINGLE + 1;
      FMT_DOUBLE: k = P_DOUBLE + 1;
      default:    k = 0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/rept_sticky_tree.sv
// Chunked OR reduction of a sticky region.
// Ports: din (W bits) in, part (one OR per CH-bit chunk) out.
module rept_sticky_tree #(
  parameter int W  = 74,
  parameter int CH = 8
) (
  input  logic [W-1:0]             din,
  output logic [(W+CH-1)/CH-1:0]   part
);

  localparam int N  = (W + CH - 1) / CH;
  localparam int PW = N * CH;

  logic [PW-1:0] pad;

  assign pad = PW'(din);

  for (genvar c = 0; c < N; c++) begin : g_or
    assign part[c] = |pad[c*CH +: CH];
  end

endmodule

// File: rtl/rept_pipe.sv
// Pipelined representation stage: packs kept bits + sticky, left-aligned.
// Ports: valid/ready in (fn, fmt, in_tag), flush, valid/ready out (f1, out_tag, err).
module rept_pipe
  import fpu_rnd_pkg::*;
#(
  parameter int IN_W   = 128,
  parameter int OUT_W  = 55,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   fn,
  input  logic [1:0]        fmt,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  f1,
  output logic [TAG_W-1:0]  out_tag,
  output logic              err
);

  localparam int KH = keep_w(FMT_HALF);
  localparam int KS = keep_w(FMT_SINGLE);
  localparam int KD = keep_w(FMT_DOUBLE);

  localparam int WH = IN_W - KH;
  localparam int WS = IN_W - KS;
  localparam int WD = IN_W - KD;

  localparam int CH = STICKY_CHUNK;
  localparam int NH = (WH + CH - 1) / CH;
  localparam int NS = (WS + CH - 1) / CH;
  localparam int ND = (WD + CH - 1) / CH;

  if (OUT_W < KD + 1 || IN_W <= KD ||
      !(STAGES == 1 || STAGES == 2)) begin : g_bad
    $error("rept_pipe: illegal parameters");
  end

  typedef struct packed {
    logic             v;
    fmt_e             fmt;
    logic [TAG_W-1:0] tag;
    logic [KD-1:0]    kept;
    logic [NH-1:0]    ph;
    logic [NS-1:0]    ps;
    logic [ND-1:0]    pd;
  } s1_t;

  logic          adv;
  logic [NH-1:0] ph;
  logic [NS-1:0] ps;
  logic [ND-1:0] pd;
  s1_t           s1_d;
  s1_t           x;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  rept_sticky_tree #(.W(WH), .CH(CH)) u_th (
    .din  (fn[WH-1:0]),
    .part (ph)
  );

  rept_sticky_tree #(.W(WS), .CH(CH)) u_ts (
    .din  (fn[WS-1:0]),
    .part (ps)
  );

  rept_sticky_tree #(.W(WD), .CH(CH)) u_td (
    .din  (fn[WD-1:0]),
    .part (pd)
  );

  always_comb begin
    s1_d      = '0;
    s1_d.v    = in_valid;
    s1_d.fmt  = fmt_e'(fmt);
    s1_d.tag  = in_tag;
    s1_d.kept = fn[IN_W-1 -: KD];
    s1_d.ph   = ph;
    s1_d.ps   = ps;
    s1_d.pd   = pd;
  end

  if (STAGES == 2) begin : g_s1
    s1_t s1_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q <= '0;
      end else begin
        if (adv)   s1_q   <= s1_d;
        if (flush) s1_q.v <= 1'b0;
      end
    end

    assign x = s1_q;
  end else begin : g_s0
    assign x = s1_d;
  end

  // Kept field left-aligned, sticky right below it, zeros under that.
  function automatic logic [OUT_W-1:0] pack(
    fmt_e          f,
    logic [KD-1:0] k,
    logic          s
  );
    logic [OUT_W-1:0] r;
    r = '0;
    unique case (f)
      FMT_HALF: begin
        r[OUT_W-1 -: KH] = k[KD-1 -: KH];
        r[OUT_W-1-KH]    = s;
      end
      FMT_SINGLE: begin
        r[OUT_W-1 -: KS] = k[KD-1 -: KS];
        r[OUT_W-1-KS]    = s;
      end
      FMT_DOUBLE: begin
        r[OUT_W-1 -: KD] = k;
        r[OUT_W-1-KD]    = s;
      end
      FMT_ILLEGAL: r = '0;
    endcase
    return r;
  endfunction

  logic             st;
  logic             err_d;
  logic [OUT_W-1:0] f1_d;

  always_comb begin
    st    = 1'b0;
    err_d = 1'b0;
    unique case (x.fmt)
      FMT_HALF:    st    = |x.ph;
      FMT_SINGLE:  st    = |x.ps;
      FMT_DOUBLE:  st    = |x.pd;
      FMT_ILLEGAL: err_d = 1'b1;
    endcase
    f1_d = pack(x.fmt, x.kept, st);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      f1        <= '0;
      out_tag   <= '0;
      err       <= 1'b0;
    end else begin
      if (adv) begin
        out_valid <= x.v;
        f1        <= f1_d;
        out_tag   <= x.tag;
        err       <= err_d;
      end
      if (flush) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rept_pipe.sv
// Directed self-checking bench for rept_pipe.
// Vector table plus back-pressure, flush and reset sequences.
module tb_rept_pipe;

  localparam int IN_W   = 128;
  localparam int OUT_W  = 55;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IN_W-1:0]   fn = '0;
  logic [1:0]        fmt = 2'b00;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OUT_W-1:0]  f1;
  logic [TAG_W-1:0]  out_tag;
  logic              err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rept_pipe #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .STAGES (STAGES),
    .TAG_W  (TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fn        (fn),
    .fmt       (fmt),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f1        (f1),
    .out_tag   (out_tag),
    .err       (err)
  );

  typedef struct {
    logic [1:0]   fmt;
    logic [127:0] fn;
    logic [3:0]   tag;
    logic [54:0]  f1;
    logic         err;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int sent;
    int got;
    int seen;
    logic        was_stall;
    logic [54:0] hold_f1;
    logic [3:0]  hold_tag;

    vt[0]  = '{2'b01, 128'h8000_0000_0000_0000_0000_0000_0000_0001,
               4'h1, 55'h40000000000001, 1'b0};
    vt[1]  = '{2'b00, 128'hFFFFFF80_00000000_00000000_00000000,
               4'h2, 55'h7FFFFFC0000000, 1'b0};
    vt[2]  = '{2'b10, 128'hFFF0_0000_0000_0000_0000_0000_0000_0001,
               4'h3, 55'h7FFC0000000000, 1'b0};
    vt[3]  = '{2'b11, {128{1'b1}},
               4'h7, 55'h0, 1'b1};
    vt[4]  = '{2'b01, {128{1'b1}},
               4'h4, 55'h7FFFFFFFFFFFFF, 1'b0};
    vt[5]  = '{2'b00, 128'h80000000_00000000_00000000_00000000,
               4'h5, 55'h40000000000000, 1'b0};
    vt[6]  = '{2'b00, 128'h00000040_00000000_00000000_00000000,
               4'h6, 55'h20000000, 1'b0};
    vt[7]  = '{2'b00, 128'h00000080_00000000_00000000_00000000,
               4'h8, 55'h40000000, 1'b0};
    vt[8]  = '{2'b10, 128'h00100000_00000000_00000000_00000000,
               4'h9, 55'h80000000000, 1'b0};
    vt[9]  = '{2'b10, 128'h00080000_00000000_00000000_00000000,
               4'hA, 55'h40000000000, 1'b0};
    vt[10] = '{2'b01, 128'h00000000_00000400_00000000_00000000,
               4'hB, 55'h2, 1'b0};
    vt[11] = '{2'b01, 128'h00000000_00000200_00000000_00000000,
               4'hC, 55'h1, 1'b0};
    vt[12] = '{2'b01, 128'h0,
               4'hD, 55'h0, 1'b0};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_f1", 64'(f1), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      fmt      = vt[i].fmt;
      fn       = vt[i].fn;
      in_tag   = vt[i].tag;
      in_valid = 1'b1;
      out_ready = 1'b1;
      chk("vec_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        tick();
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(STAGES));
      chk($sformatf("vec%0d_f1", i), 64'(f1), 64'(vt[i].f1));
      chk($sformatf("vec%0d_err", i), 64'(err), 64'(vt[i].err));
      chk($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(vt[i].tag));
      tick();
    end

    sent = 0;
    got = 0;
    was_stall = 1'b0;
    hold_f1 = '0;
    hold_tag = '0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      out_ready = !(cyc >= 3 && cyc < 7);
      in_valid  = (sent < 6);
      fmt       = 2'b01;
      fn        = (128'(sent + 1) << 120) | 128'(sent & 1);
      in_tag    = 4'(sent);
      #1;
      if (out_valid && !out_ready) begin
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        if (was_stall) begin
          chk("bp_hold_f1", 64'(f1), 64'(hold_f1));
          chk("bp_hold_tag", 64'(out_tag), 64'(hold_tag));
        end
        hold_f1   = f1;
        hold_tag  = out_tag;
        was_stall = 1'b1;
      end else begin
        was_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp%0d_tag", got), 64'(out_tag), 64'(got));
        chk($sformatf("bp%0d_f1", got), 64'(f1),
            64'((55'(got + 1) << 47) | 55'(got & 1)));
        chk($sformatf("bp%0d_err", got), 64'(err), 64'd0);
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(got), 64'd6);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("bp_no_dup", 64'(seen), 64'd0);

    out_ready = 1'b0;
    fmt       = 2'b01;
    fn        = {128{1'b1}};
    in_tag    = 4'h8;
    in_valid  = 1'b1;
    tick();
    in_tag = 4'h9;
    tick();
    chk("fl_pre_valid", 64'(out_valid), 64'd1);
    flush  = 1'b1;
    in_tag = 4'hA;
    tick();
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("fl_leak", 64'(seen), 64'd0);

    flush    = 1'b1;
    in_valid = 1'b1;
    in_tag   = 4'hE;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("fl_drop_input", 64'(seen), 64'd0);

    out_ready = 1'b0;
    fmt       = 2'b01;
    fn        = {128{1'b1}};
    in_tag    = 4'h3;
    in_valid  = 1'b1;
    tick();
    fmt    = 2'b11;
    in_tag = 4'h4;
    tick();
    in_valid = 1'b0;
    chk("rs_pre_f1", 64'(f1), 64'h7FFFFFFFFFFFFF);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_out_valid", 64'(out_valid), 64'd0);
    chk("rs_f1", 64'(f1), 64'd0);
    chk("rs_err", 64'(err), 64'd0);
    chk("rs_out_tag", 64'(out_tag), 64'd0);
    #3 rst_n = 1'b1;
    #1;
    chk("rs_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("rs_discard", 64'(seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
